reu_regs: RTL and testbench
===========================

Name: reu_regs

Overview:
- C64-side register file of the Super REU, mapped at $DF00-$DF1F (IO2), 1764/1750-compatible register layout.
- Consumes the raw cartridge bus signals (I/O strobe, address, R/W, data) and drives read data back onto low_d.
- Holds the DMA setup: addresses, length, interrupt mask and address control.
- Hands transfers to the downstream DMA engine through a start/busy/done handshake and accepts its address and length write-back.

Parameters:
- bank_bits, 3, number of implemented REU bank bits (1..8). Unimplemented bits of register 6 read as 1.
- size_flag, 1, constant value returned in status bit 4.

Ports:
- clk  in  1  system clock (sysclk)
- reset  in  1  synchronous, active-high
- io_n  in  1  raw C64 I/O strobe, active low, asynchronous
- addr  in  16  C64 address bus (low_a)
- rw  in  1  C64 R/W, 1 = read
- wdata  in  8  C64 data bus input
- rdata  out  8  register read data
- rdata_oe  out  1  drive low_d with rdata
- ff00_write  in  1  one-cycle pulse: CPU wrote $FF00
- dma_start  out  1  one-cycle pulse: begin transfer
- dma_busy  in  1  DMA engine active
- dma_done  in  1  one-cycle pulse: transfer finished
- dma_eob  in  1  end-of-block flag, valid with dma_done
- dma_fault  in  1  verify-error flag, valid with dma_done
- wb_c64_addr  in  16  final C64 address, valid with dma_done
- wb_reu_addr  in  24  final REU address, valid with dma_done
- wb_len  in  16  final length, valid with dma_done
- cmd_type  out  2  transfer type (command bits 1:0)
- fix_c64  out  1  address-control bit 7
- fix_reu  out  1  address-control bit 6
- c64_addr  out  16  registers 3:2
- reu_addr  out  24  registers 6:4
- xfer_len  out  16  registers 8:7
- irq  out  1  interrupt request, active high

Behaviour:
- io_n passes through a 2-flop synchronizer.
- Access start = synced falling edge. Access end = synced rising edge.
- Select = start with addr[15:8] == 8'hDF. addr[4:0] is latched at start; registers mirror every 32 bytes.
- Read access:
  - rdata is registered at start + 1 from the latched index.
  - rdata_oe is high from start + 1 until the end edge.
  - rw is sampled at start.
- Write access: addr and wdata are sampled every cycle while active. The commit happens on the end edge using the last sample.
- Register map, with reset values:
  - 0 status: bit7 irq pending, bit6 eob, bit5 fault, bit4 size_flag, bits3:0 = 0. Read-only. Bits 7:5 clear at the end edge of a status read.
  - 1 command: reset 8'h10. Bit7 execute, bit5 autoload, bit4 ff00-disable, bits1:0 type. Bits 6 and 3:2 read 0.
  - 2-3 C64 address: reset 0.
  - 4-6 REU address: reset 0. Register 6 keeps bank_bits bits.
  - 7-8 length: reset 16'hFFFF. A value of 0 means 65536; the engine interprets this.
  - 9 int mask: bit7 ie, bit6 eob-ie, bit5 fault-ie. Bits 4:0 read 1. Reset reads 8'h1F.
  - 10 address control: bits 7:6. Bits 5:0 read 1. Reset reads 8'h3F.
  - 11-31: read 8'hFF, writes ignored.
- Any write to registers 2-8 also updates the shadow copy of that register.
- State machine, states IDLE, ARMED, RUN:
  - IDLE -> command written with bit7 = 1:
    - If bit4 = 1: dma_start pulses the cycle after commit, next state RUN.
    - Otherwise, next state ARMED.
  - ARMED -> ff00_write: dma_start pulses the next cycle, next state RUN.
  - ARMED -> command rewritten with bit7 = 0: back to IDLE.
  - Command bit7 clears when dma_start is issued.
  - RUN -> dma_done: status bit6 = dma_eob and bit5 = dma_fault, both OR-ed into the existing bits. Next state IDLE.
    - Autoload = 1: registers 2-8 reload from the shadow copies.
    - Autoload = 0: registers 2-8 load the wb_* values.
- CPU writes are ignored while dma_busy = 1 or while in RUN. Reads are served normally.
- Simultaneous events:
  - dma_done together with a write commit: the write is dropped.
  - dma_done together with a status-read clear: the new flags survive.
- Status bit7 = bit7 of register 9 AND ((eob AND eob-ie) OR (fault AND fault-ie)). irq = status bit7, registered.
- Reset, including mid-transfer: all registers and shadow copies return to their reset values, state = IDLE.
  - Outputs at reset: dma_start = 0, rdata_oe = 0, rdata = 0, irq = 0.
  - A dma_done arriving after reset is ignored (state is IDLE).

Test Plan:
- Reset, then read $DF00-$DF0B -> 8'h10, 8'h10, 00, 00, 00, 00, F8 (bank_bits = 3), FF, FF, 1F, 3F, FF. rdata_oe goes high only during the read strobes.
- Write $DF02 = 34, $DF03 = 12, $DF0A = C0 -> c64_addr = 16'h1234, fix_c64 = 1, fix_reu = 1. Reading $DF22 returns 34 (mirror).
- Write $DF01 = 8'h90 -> one dma_start pulse 1 cycle after the end edge; reading $DF01 returns 8'h10.
- Write $DF01 = 8'h80, wait 20 cycles (no start), then pulse ff00_write -> dma_start follows on the next cycle.
- Setup: $DF09 = C0, autoload = 0, transfer running.
  - dma_done with eob = 1, wb_len = 1 -> irq = 1, $DF08:$DF07 = 0001.
  - Status read returns 8'hD0 (size_flag = 1). irq drops after the end edge. A second status read returns 8'h10.
- Autoload = 1, C64 address 16'h1234, dma_done with wb_c64_addr = 16'h1300 -> c64_addr = 16'h1234. Assert reset during RUN -> regs at their reset values, and a subsequent dma_done leaves status at 8'h10.

Source files
------------

// File: rtl/reu_regs.sv
// reu_regs: C64-side register file of the Super REU, decoded at $DF00-$DF1F.
// Watches the raw cartridge bus, serves register reads and commits register
// writes, and hands DMA jobs to the engine through a start/busy/done handshake.
module reu_regs #(
    parameter int   bank_bits = 3,
    parameter logic size_flag = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_n,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rdata_oe,
    input  logic        ff00_write,
    output logic        dma_start,
    input  logic        dma_busy,
    input  logic        dma_done,
    input  logic        dma_eob,
    input  logic        dma_fault,
    input  logic [15:0] wb_c64_addr,
    input  logic [23:0] wb_reu_addr,
    input  logic [15:0] wb_len,
    output logic [1:0]  cmd_type,
    output logic        fix_c64,
    output logic        fix_reu,
    output logic [15:0] c64_addr,
    output logic [23:0] reu_addr,
    output logic [15:0] xfer_len,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Bus interface state
    // ------------------------------------------------------------------
    logic       io_s1_q, io_s2_q, io_prev_q;
    logic       active_q;
    logic       rw_q;
    logic       rd_pend_q;
    logic       rdata_oe_q;
    logic [4:0] idx_q;
    logic [4:0] wr_idx_q;
    logic [7:0] wr_data_q;
    logic [7:0] rdata_q;
    logic [7:0] rd_mux;

    logic acc_start;
    logic acc_end;
    logic wr_commit;
    logic wr_ok;
    logic cmd_wr;
    logic stat_clear;
    logic done_ev;

    // ------------------------------------------------------------------
    // Register file state
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   start_issue;
    logic   dma_start_q;

    logic       cmd_exec_q, cmd_exec_d;
    logic       cmd_auto_q, cmd_auto_d;
    logic       cmd_ff00dis_q, cmd_ff00dis_d;
    logic [1:0] cmd_type_q, cmd_type_d;

    logic [15:0]          c64_q, c64_d;
    logic [15:0]          reu_lo_q, reu_lo_d;
    logic [bank_bits-1:0] bank_q, bank_d;
    logic [15:0]          len_q, len_d;

    logic [15:0]          sh_c64_q, sh_c64_d;
    logic [15:0]          sh_reu_lo_q, sh_reu_lo_d;
    logic [bank_bits-1:0] sh_bank_q, sh_bank_d;
    logic [15:0]          sh_len_q, sh_len_d;

    logic ie_q, ie_d;
    logic eob_ie_q, eob_ie_d;
    logic fault_ie_q, fault_ie_d;
    logic fix_c64_q, fix_c64_d;
    logic fix_reu_q, fix_reu_d;
    logic eob_q, eob_d;
    logic fault_q, fault_d;
    logic irq_pend;
    logic irq_q;

    logic [7:0] reg6_rd;
    logic       unused_bits;

    // The strobe is asynchronous; edges are only detected after two flops.
    assign acc_start  = io_prev_q & ~io_s2_q & (addr[15:8] == 8'hDF);
    assign acc_end    = active_q & ~io_prev_q & io_s2_q;
    assign wr_commit  = acc_end & ~rw_q;
    assign done_ev    = dma_done & (state_q == ST_RUN);
    // A commit colliding with dma_done loses; the engine write-back wins.
    assign wr_ok      = wr_commit & ~dma_busy & (state_q != ST_RUN) & ~dma_done;
    assign cmd_wr     = wr_ok & (wr_idx_q == 5'd1);
    assign stat_clear = acc_end & rw_q & (idx_q == 5'd0);

    assign irq_pend = ie_q & ((eob_q & eob_ie_q) | (fault_q & fault_ie_q));

    // Register 6 keeps only the implemented bank bits; the rest read as 1.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg6
            if (gi < bank_bits) begin : g_impl
                assign reg6_rd[gi] = bank_q[gi];
            end else begin : g_pad
                assign reg6_rd[gi] = 1'b1;
            end
        end
    endgenerate

    // Synchronize the strobe, track the access and capture read/write data.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_s1_q    <= 1'b1;
            io_s2_q    <= 1'b1;
            io_prev_q  <= 1'b1;
            active_q   <= 1'b0;
            rw_q       <= 1'b1;
            rd_pend_q  <= 1'b0;
            rdata_oe_q <= 1'b0;
            rdata_q    <= 8'h00;
            idx_q      <= 5'd0;
            wr_idx_q   <= 5'd0;
            wr_data_q  <= 8'h00;
        end else begin
            io_s1_q   <= io_n;
            io_s2_q   <= io_s1_q;
            io_prev_q <= io_s2_q;
            rd_pend_q <= acc_start & rw;
            if (acc_start) begin
                active_q <= 1'b1;
                rw_q     <= rw;
                idx_q    <= addr[4:0];
            end else if (acc_end) begin
                active_q <= 1'b0;
            end
            if (rd_pend_q) begin
                rdata_q    <= rd_mux;
                rdata_oe_q <= 1'b1;
            end
            if (acc_end) begin
                rdata_oe_q <= 1'b0;
            end
            // Write data settles late on the C64 bus; keep the freshest sample.
            if ((acc_start & ~rw) | (active_q & ~rw_q)) begin
                wr_idx_q  <= addr[4:0];
                wr_data_q <= wdata;
            end
        end
    end

    // Read multiplexer over the latched register index.
    always_comb begin
        rd_mux = 8'hFF;
        case (idx_q)
            5'd0:    rd_mux = {irq_pend, eob_q, fault_q, size_flag, 4'b0000};
            5'd1:    rd_mux = {cmd_exec_q, 1'b0, cmd_auto_q, cmd_ff00dis_q, 2'b00, cmd_type_q};
            5'd2:    rd_mux = c64_q[7:0];
            5'd3:    rd_mux = c64_q[15:8];
            5'd4:    rd_mux = reu_lo_q[7:0];
            5'd5:    rd_mux = reu_lo_q[15:8];
            5'd6:    rd_mux = reg6_rd;
            5'd7:    rd_mux = len_q[7:0];
            5'd8:    rd_mux = len_q[15:8];
            5'd9:    rd_mux = {ie_q, eob_ie_q, fault_ie_q, 5'b11111};
            5'd10:   rd_mux = {fix_c64_q, fix_reu_q, 6'b111111};
            default: rd_mux = 8'hFF;
        endcase
    end

    // Transfer sequencing: next state and start request.
    always_comb begin
        state_d     = state_q;
        start_issue = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_wr && wr_data_q[7]) begin
                    if (wr_data_q[4]) begin
                        start_issue = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (ff00_write) begin
                    start_issue = 1'b1;
                    state_d     = ST_RUN;
                end else if (cmd_wr && !wr_data_q[7]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (dma_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register file next state: CPU writes, start handshake and DMA write-back.
    always_comb begin
        cmd_exec_d    = cmd_exec_q;
        cmd_auto_d    = cmd_auto_q;
        cmd_ff00dis_d = cmd_ff00dis_q;
        cmd_type_d    = cmd_type_q;
        c64_d         = c64_q;
        reu_lo_d      = reu_lo_q;
        bank_d        = bank_q;
        len_d         = len_q;
        sh_c64_d      = sh_c64_q;
        sh_reu_lo_d   = sh_reu_lo_q;
        sh_bank_d     = sh_bank_q;
        sh_len_d      = sh_len_q;
        ie_d          = ie_q;
        eob_ie_d      = eob_ie_q;
        fault_ie_d    = fault_ie_q;
        fix_c64_d     = fix_c64_q;
        fix_reu_d     = fix_reu_q;

        if (wr_ok) begin
            case (wr_idx_q)
                5'd1: begin
                    cmd_exec_d    = wr_data_q[7];
                    cmd_auto_d    = wr_data_q[5];
                    cmd_ff00dis_d = wr_data_q[4];
                    cmd_type_d    = wr_data_q[1:0];
                end
                5'd2: begin
                    c64_d[7:0]    = wr_data_q;
                    sh_c64_d[7:0] = wr_data_q;
                end
                5'd3: begin
                    c64_d[15:8]    = wr_data_q;
                    sh_c64_d[15:8] = wr_data_q;
                end
                5'd4: begin
                    reu_lo_d[7:0]    = wr_data_q;
                    sh_reu_lo_d[7:0] = wr_data_q;
                end
                5'd5: begin
                    reu_lo_d[15:8]    = wr_data_q;
                    sh_reu_lo_d[15:8] = wr_data_q;
                end
                5'd6: begin
                    bank_d    = wr_data_q[bank_bits-1:0];
                    sh_bank_d = wr_data_q[bank_bits-1:0];
                end
                5'd7: begin
                    len_d[7:0]    = wr_data_q;
                    sh_len_d[7:0] = wr_data_q;
                end
                5'd8: begin
                    len_d[15:8]    = wr_data_q;
                    sh_len_d[15:8] = wr_data_q;
                end
                5'd9: begin
                    ie_d       = wr_data_q[7];
                    eob_ie_d   = wr_data_q[6];
                    fault_ie_d = wr_data_q[5];
                end
                5'd10: begin
                    fix_c64_d = wr_data_q[7];
                    fix_reu_d = wr_data_q[6];
                end
                default: ;
            endcase
        end

        // Execute is self-clearing once the engine has been told to go.
        if (start_issue) begin
            cmd_exec_d = 1'b0;
        end

        if (done_ev) begin
            if (cmd_auto_q) begin
                c64_d    = sh_c64_q;
                reu_lo_d = sh_reu_lo_q;
                bank_d   = sh_bank_q;
                len_d    = sh_len_q;
            end else begin
                c64_d    = wb_c64_addr;
                reu_lo_d = wb_reu_addr[15:0];
                bank_d   = wb_reu_addr[16 +: bank_bits];
                len_d    = wb_len;
            end
        end

        // New completion flags survive a simultaneous status-read clear.
        eob_d   = (stat_clear ? 1'b0 : eob_q)   | (done_ev & dma_eob);
        fault_d = (stat_clear ? 1'b0 : fault_q) | (done_ev & dma_fault);
    end

    // State and register file flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            dma_start_q   <= 1'b0;
            cmd_exec_q    <= 1'b0;
            cmd_auto_q    <= 1'b0;
            cmd_ff00dis_q <= 1'b1;
            cmd_type_q    <= 2'b00;
            c64_q         <= 16'h0000;
            reu_lo_q      <= 16'h0000;
            bank_q        <= '0;
            len_q         <= 16'hFFFF;
            sh_c64_q      <= 16'h0000;
            sh_reu_lo_q   <= 16'h0000;
            sh_bank_q     <= '0;
            sh_len_q      <= 16'hFFFF;
            ie_q          <= 1'b0;
            eob_ie_q      <= 1'b0;
            fault_ie_q    <= 1'b0;
            fix_c64_q     <= 1'b0;
            fix_reu_q     <= 1'b0;
            eob_q         <= 1'b0;
            fault_q       <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            dma_start_q   <= start_issue;
            cmd_exec_q    <= cmd_exec_d;
            cmd_auto_q    <= cmd_auto_d;
            cmd_ff00dis_q <= cmd_ff00dis_d;
            cmd_type_q    <= cmd_type_d;
            c64_q         <= c64_d;
            reu_lo_q      <= reu_lo_d;
            bank_q        <= bank_d;
            len_q         <= len_d;
            sh_c64_q      <= sh_c64_d;
            sh_reu_lo_q   <= sh_reu_lo_d;
            sh_bank_q     <= sh_bank_d;
            sh_len_q      <= sh_len_d;
            ie_q          <= ie_d;
            eob_ie_q      <= eob_ie_d;
            fault_ie_q    <= fault_ie_d;
            fix_c64_q     <= fix_c64_d;
            fix_reu_q     <= fix_reu_d;
            eob_q         <= eob_d;
            fault_q       <= fault_d;
            irq_q         <= irq_pend;
        end
    end

    assign rdata     = rdata_q;
    assign rdata_oe  = rdata_oe_q;
    assign dma_start = dma_start_q;
    assign cmd_type  = cmd_type_q;
    assign fix_c64   = fix_c64_q;
    assign fix_reu   = fix_reu_q;
    assign c64_addr  = c64_q;
    assign reu_addr  = {reg6_rd, reu_lo_q};
    assign xfer_len  = len_q;
    assign irq       = irq_q;

    // Address bits 7:5 are don't-care (mirroring); upper write-back bank bits
    // beyond the implemented ones are dropped.
    assign unused_bits = ^{addr[7:5], wb_reu_addr[23:16], wr_data_q};

endmodule

// File: tb/tb_reu_regs.sv
// tb_reu_regs: bus-level bench for reu_regs with a byte-oriented register model.
module tb_reu_regs;

    localparam int         BANK_BITS = 3;
    localparam logic [7:0] BANK_MASK = 8'((1 << BANK_BITS) - 1);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_n = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic        rw = 1'b1;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        rdata_oe;
    logic        ff00_write = 1'b0;
    logic        dma_start;
    logic        dma_busy = 1'b0;
    logic        dma_done = 1'b0;
    logic        dma_eob = 1'b0;
    logic        dma_fault = 1'b0;
    logic [15:0] wb_c64_addr = 16'h0000;
    logic [23:0] wb_reu_addr = 24'h000000;
    logic [15:0] wb_len = 16'h0000;
    logic [1:0]  cmd_type;
    logic        fix_c64;
    logic        fix_reu;
    logic [15:0] c64_addr;
    logic [23:0] reu_addr;
    logic [15:0] xfer_len;
    logic        irq;

    int n_tests = 0;
    int n_fail = 0;
    int start_cnt = 0;

    // Reference model: register bytes as stored, shadow bytes, flags, job state.
    logic [7:0] m_reg [0:10];
    logic [7:0] m_sh  [2:8];
    logic       m_eob, m_fault, m_run, m_armed;

    reu_regs #(.bank_bits(BANK_BITS), .size_flag(1'b1)) dut (
        .clk(clk), .reset(reset), .io_n(io_n), .addr(addr), .rw(rw),
        .wdata(wdata), .rdata(rdata), .rdata_oe(rdata_oe),
        .ff00_write(ff00_write), .dma_start(dma_start), .dma_busy(dma_busy),
        .dma_done(dma_done), .dma_eob(dma_eob), .dma_fault(dma_fault),
        .wb_c64_addr(wb_c64_addr), .wb_reu_addr(wb_reu_addr), .wb_len(wb_len),
        .cmd_type(cmd_type), .fix_c64(fix_c64), .fix_reu(fix_reu),
        .c64_addr(c64_addr), .reu_addr(reu_addr), .xfer_len(xfer_len), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dma_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic model_irq();
        return m_reg[9][7] & ((m_eob & m_reg[9][6]) | (m_fault & m_reg[9][5]));
    endfunction

    function automatic logic [7:0] exp_read(input int idx);
        if (idx == 0) return {model_irq(), m_eob, m_fault, 1'b1, 4'b0000};
        if (idx == 6) return m_reg[6] | ~BANK_MASK;
        if (idx == 9) return m_reg[9] | 8'h1F;
        if (idx == 10) return m_reg[10] | 8'h3F;
        if (idx > 10) return 8'hFF;
        return m_reg[idx];
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= 10; k++) m_reg[k] = 8'h00;
        m_reg[1] = 8'h10;
        m_reg[7] = 8'hFF;
        m_reg[8] = 8'hFF;
        for (int k = 2; k <= 8; k++) m_sh[k] = m_reg[k];
        m_eob = 1'b0; m_fault = 1'b0; m_run = 1'b0; m_armed = 1'b0;
    endtask

    task automatic model_write(input int idx, input logic [7:0] d);
        if (m_run || dma_busy) return;
        case (idx)
            1: begin
                m_reg[1] = d & 8'hB3;
                if (m_armed) begin
                    if (!d[7]) m_armed = 1'b0;
                end else if (d[7]) begin
                    if (d[4]) begin
                        m_reg[1][7] = 1'b0;
                        m_run = 1'b1;
                    end else begin
                        m_armed = 1'b1;
                    end
                end
            end
            2, 3, 4, 5, 7, 8: begin
                m_reg[idx] = d;
                m_sh[idx] = d;
            end
            6: begin
                m_reg[6] = d & BANK_MASK;
                m_sh[6] = d & BANK_MASK;
            end
            9: m_reg[9] = d & 8'hE0;
            10: m_reg[10] = d & 8'hC0;
            default: ;
        endcase
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; rw = 1'b0; io_n = 1'b0;
        repeat (6) @(negedge clk);
        io_n = 1'b1;
        repeat (5) @(negedge clk);
        addr = 16'h0000; rw = 1'b1;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d,
                            output logic oe_mid, output logic oe_after);
        @(negedge clk);
        addr = a; rw = 1'b1; io_n = 1'b0;
        repeat (6) @(negedge clk);
        d = rdata;
        oe_mid = rdata_oe;
        io_n = 1'b1;
        repeat (5) @(negedge clk);
        oe_after = rdata_oe;
        addr = 16'h0000;
        if (a[4:0] == 5'd0) begin
            m_eob = 1'b0;
            m_fault = 1'b0;
        end
    endtask

    task automatic pulse_done(input logic eob, input logic fault, input logic [15:0] wc,
                              input logic [23:0] wr, input logic [15:0] wl);
        @(negedge clk);
        dma_done = 1'b1; dma_eob = eob; dma_fault = fault;
        wb_c64_addr = wc; wb_reu_addr = wr; wb_len = wl;
        @(negedge clk);
        dma_done = 1'b0; dma_eob = 1'b0; dma_fault = 1'b0; dma_busy = 1'b0;
        if (m_run) begin
            m_run = 1'b0;
            m_eob = m_eob | eob;
            m_fault = m_fault | fault;
            if (m_reg[1][5]) begin
                for (int k = 2; k <= 8; k++) m_reg[k] = m_sh[k];
            end else begin
                m_reg[2] = wc[7:0];  m_reg[3] = wc[15:8];
                m_reg[4] = wr[7:0];  m_reg[5] = wr[15:8];
                m_reg[6] = wr[23:16] & BANK_MASK;
                m_reg[7] = wl[7:0];  m_reg[8] = wl[15:8];
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] exp_tab [0:11];
        logic [7:0] d;
        logic oe_m, oe_a;
        exp_tab = '{8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'hF8, 8'hFF, 8'hFF, 8'h1F, 8'h3F, 8'hFF};
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({dma_start, rdata_oe, irq, rdata} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got start=%b oe=%b irq=%b rdata=%h required all 0",
                     dma_start, rdata_oe, irq, rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (c64_addr !== 16'h0000 || xfer_len !== 16'hFFFF || fix_c64 !== 1'b0 || cmd_type !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_regs: got c64=%h len=%h fix=%b type=%b required 0000 FFFF 0 00",
                     c64_addr, xfer_len, fix_c64, cmd_type);
        end
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (rdata_oe !== 1'b0) begin
                n_fail++;
                $display("FAIL oe_idle: got %b required 0 before read %0d", rdata_oe, i);
            end
            bus_read(16'hDF00 + 16'(i), d, oe_m, oe_a);
            n_tests++;
            if (d !== exp_tab[i] || oe_m !== 1'b1 || oe_a !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got %h oe=%b/%b required %h oe=1/0",
                         i, d, oe_m, oe_a, exp_tab[i]);
            end
        end
    endtask

    task automatic test_basic_writes();
        logic [7:0] d;
        logic oe_m, oe_a;
        bus_write(16'hDF02, 8'h34); model_write(2, 8'h34);
        bus_write(16'hDF03, 8'h12); model_write(3, 8'h12);
        bus_write(16'hDF0A, 8'hC0); model_write(10, 8'hC0);
        n_tests++;
        if (c64_addr !== 16'h1234 || fix_c64 !== 1'b1 || fix_reu !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_writes: got c64=%h fix=%b%b required 1234 11",
                     c64_addr, fix_c64, fix_reu);
        end
        bus_read(16'hDF22, d, oe_m, oe_a);
        n_tests++;
        if (d !== 8'h34) begin
            n_fail++;
            $display("FAIL mirror_read: got %h required 34", d);
        end
    endtask

    task automatic test_random_regs();
        int idx;
        logic [7:0] d, r;
        logic oe_m, oe_a;
        logic [15:0] a;
        for (int n = 0; n < 40; n++) begin
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(11, 31)) : int'($urandom_range(2, 10));
            d = 8'($urandom);
            a = 16'hDF00 | 16'(($urandom_range(0, 7) << 5) | idx);
            bus_write(a, d);
            model_write(idx, d);
            idx = int'($urandom_range(0, 31));
            a = 16'hDF00 | 16'(($urandom_range(0, 7) << 5) | idx);
            d = exp_read(idx);
            bus_read(a, r, oe_m, oe_a);
            n_tests++;
            if (r !== d) begin
                n_fail++;
                $display("FAIL rand_read[%0d] addr %h: got %h required %h", n, a, r, d);
            end
        end
        n_tests++;
        if (c64_addr !== {m_reg[3], m_reg[2]} || xfer_len !== {m_reg[8], m_reg[7]} ||
            reu_addr[15:0] !== {m_reg[5], m_reg[4]} ||
            reu_addr[16 +: BANK_BITS] !== m_reg[6][BANK_BITS-1:0] ||
            fix_c64 !== m_reg[10][7] || fix_reu !== m_reg[10][6]) begin
            n_fail++;
            $display("FAIL rand_outputs: got c64=%h reu=%h len=%h fix=%b%b required c64=%h lo=%h len=%h",
                     c64_addr, reu_addr, xfer_len, fix_c64, fix_reu,
                     {m_reg[3], m_reg[2]}, {m_reg[5], m_reg[4]}, {m_reg[8], m_reg[7]});
        end
    endtask

    task automatic test_direct_start();
        int c0;
        logic [7:0] d;
        logic oe_m, oe_a;
        c0 = start_cnt;
        bus_write(16'hDF01, 8'h90); model_write(1, 8'h90);
        n_tests++;
        if (start_cnt - c0 !== 1) begin
            n_fail++;
            $display("FAIL direct_start: got %0d pulses required 1", start_cnt - c0);
        end
        bus_read(16'hDF01, d, oe_m, oe_a);
        n_tests++;
        if (d !== 8'h10) begin
            n_fail++;
            $display("FAIL exec_clear: got %h required 10", d);
        end
        // In RUN with the engine idle-flagged: the write must still be dropped.
        bus_write(16'hDF04, 8'h55); model_write(4, 8'h55);
        n_tests++;
        if (reu_addr[7:0] !== m_reg[4]) begin
            n_fail++;
            $display("FAIL run_write_ignored: got %h required %h", reu_addr[7:0], m_reg[4]);
        end
        pulse_done(1'b0, 1'b0, 16'($urandom), 24'($urandom), 16'($urandom));
        n_tests++;
        if (c64_addr !== {m_reg[3], m_reg[2]} || xfer_len !== {m_reg[8], m_reg[7]}) begin
            n_fail++;
            $display("FAIL wb_load: got c64=%h len=%h required %h %h",
                     c64_addr, xfer_len, {m_reg[3], m_reg[2]}, {m_reg[8], m_reg[7]});
        end
        dma_busy = 1'b1;
        bus_write(16'hDF05, 8'h66); model_write(5, 8'h66);
        dma_busy = 1'b0;
        n_tests++;
        if (reu_addr[15:8] !== m_reg[5]) begin
            n_fail++;
            $display("FAIL busy_write_ignored: got %h required %h", reu_addr[15:8], m_reg[5]);
        end
    endtask

    task automatic test_ff00();
        int c0;
        logic [7:0] d;
        logic oe_m, oe_a;
        c0 = start_cnt;
        bus_write(16'hDF01, 8'h80); model_write(1, 8'h80);
        bus_write(16'hDF01, 8'h00); model_write(1, 8'h00);
        @(negedge clk); ff00_write = 1'b1;
        @(negedge clk); ff00_write = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (start_cnt !== c0) begin
            n_fail++;
            $display("FAIL disarm: got %0d pulses required 0", start_cnt - c0);
        end
        bus_write(16'hDF01, 8'h80); model_write(1, 8'h80);
        repeat (20) @(negedge clk);
        n_tests++;
        if (start_cnt !== c0) begin
            n_fail++;
            $display("FAIL armed_wait: got %0d pulses required 0", start_cnt - c0);
        end
        ff00_write = 1'b1;
        @(negedge clk); ff00_write = 1'b0;
        n_tests++;
        if (dma_start !== 1'b1) begin
            n_fail++;
            $display("FAIL ff00_start: got %b required 1", dma_start);
        end
        @(negedge clk);
        n_tests++;
        if (dma_start !== 1'b0 || start_cnt - c0 !== 1) begin
            n_fail++;
            $display("FAIL ff00_pulse: got start=%b pulses=%0d required 0 and 1", dma_start, start_cnt - c0);
        end
        m_reg[1][7] = 1'b0; m_run = 1'b1; m_armed = 1'b0;
        dma_busy = 1'b1;
        bus_read(16'hDF01, d, oe_m, oe_a);
        n_tests++;
        if (d !== exp_read(1)) begin
            n_fail++;
            $display("FAIL ff00_exec_clear: got %h required %h", d, exp_read(1));
        end
        pulse_done(1'b0, 1'b0, 16'($urandom), 24'($urandom), 16'($urandom));
    endtask

    task automatic test_irq();
        logic [7:0] d;
        logic oe_m, oe_a;
        bus_write(16'hDF09, 8'hC0); model_write(9, 8'hC0);
        bus_write(16'hDF01, 8'h90); model_write(1, 8'h90);
        dma_busy = 1'b1;
        pulse_done(1'b1, 1'b0, 16'($urandom), 24'($urandom), 16'h0001);
        n_tests++;
        if (irq !== 1'b1 || xfer_len !== 16'h0001) begin
            n_fail++;
            $display("FAIL irq_set: got irq=%b len=%h required 1 0001", irq, xfer_len);
        end
        bus_read(16'hDF08, d, oe_m, oe_a);
        n_tests++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL len_hi: got %h required 00", d);
        end
        bus_read(16'hDF07, d, oe_m, oe_a);
        n_tests++;
        if (d !== 8'h01) begin
            n_fail++;
            $display("FAIL len_lo: got %h required 01", d);
        end
        bus_read(16'hDF00, d, oe_m, oe_a);
        n_tests++;
        if (d !== 8'hD0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL status_read: got %h irq_after=%b required D0 0", d, irq);
        end
        bus_read(16'hDF00, d, oe_m, oe_a);
        n_tests++;
        if (d !== 8'h10) begin
            n_fail++;
            $display("FAIL status_cleared: got %h required 10", d);
        end
    endtask

    task automatic test_random_xfers();
        logic [7:0] mask, cmd, d, e;
        logic oe_m, oe_a, eob, fault;
        int c0;
        for (int n = 0; n < 8; n++) begin
            mask = 8'($urandom) & 8'hE0;
            bus_write(16'hDF09, mask); model_write(9, mask);
            d = 8'($urandom);
            bus_write(16'hDF07, d); model_write(7, d);
            cmd = {1'b1, 1'b0, 1'($urandom), 1'b1, 2'b00, 2'($urandom)};
            c0 = start_cnt;
            bus_write(16'hDF01, cmd); model_write(1, cmd);
            dma_busy = 1'b1;
            n_tests++;
            if (start_cnt - c0 !== 1 || cmd_type !== cmd[1:0]) begin
                n_fail++;
                $display("FAIL xfer_start[%0d]: got pulses=%0d type=%b required 1 %b",
                         n, start_cnt - c0, cmd_type, cmd[1:0]);
            end
            eob = 1'($urandom); fault = 1'($urandom);
            pulse_done(eob, fault, 16'($urandom), 24'($urandom), 16'($urandom));
            n_tests++;
            if (irq !== model_irq() || c64_addr !== {m_reg[3], m_reg[2]} ||
                xfer_len !== {m_reg[8], m_reg[7]} || reu_addr[15:0] !== {m_reg[5], m_reg[4]}) begin
                n_fail++;
                $display("FAIL xfer_done[%0d]: got irq=%b c64=%h len=%h reu=%h required irq=%b c64=%h len=%h lo=%h",
                         n, irq, c64_addr, xfer_len, reu_addr, model_irq(),
                         {m_reg[3], m_reg[2]}, {m_reg[8], m_reg[7]}, {m_reg[5], m_reg[4]});
            end
            e = exp_read(0);
            bus_read(16'hDF00, d, oe_m, oe_a);
            n_tests++;
            if (d !== e || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL xfer_status[%0d]: got %h irq=%b required %h 0", n, d, irq, e);
            end
        end
    endtask

    task automatic test_autoload_reset();
        int c0;
        logic [7:0] d;
        logic oe_m, oe_a;
        bus_write(16'hDF02, 8'h34); model_write(2, 8'h34);
        bus_write(16'hDF03, 8'h12); model_write(3, 8'h12);
        bus_write(16'hDF01, 8'hB0); model_write(1, 8'hB0);
        dma_busy = 1'b1;
        pulse_done(1'b0, 1'b0, 16'h1300, 24'($urandom), 16'($urandom));
        n_tests++;
        if (c64_addr !== 16'h1234 || xfer_len !== {m_reg[8], m_reg[7]} ||
            reu_addr[15:0] !== {m_reg[5], m_reg[4]}) begin
            n_fail++;
            $display("FAIL autoload: got c64=%h len=%h reu=%h required 1234 %h lo=%h",
                     c64_addr, xfer_len, reu_addr, {m_reg[8], m_reg[7]}, {m_reg[5], m_reg[4]});
        end
        bus_write(16'hDF01, 8'hB0); model_write(1, 8'hB0);
        dma_busy = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1; dma_busy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (c64_addr !== 16'h0000 || xfer_len !== 16'hFFFF || reu_addr[15:0] !== 16'h0000 ||
            irq !== 1'b0 || dma_start !== 1'b0) begin
            n_fail++;
            $display("FAIL run_reset: got c64=%h len=%h reu=%h irq=%b start=%b required 0000 FFFF 0000 0 0",
                     c64_addr, xfer_len, reu_addr, irq, dma_start);
        end
        c0 = start_cnt;
        pulse_done(1'b1, 1'b1, 16'hAAAA, 24'h555555, 16'h0001);
        bus_read(16'hDF00, d, oe_m, oe_a);
        n_tests++;
        if (d !== 8'h10 || irq !== 1'b0 || start_cnt !== c0) begin
            n_fail++;
            $display("FAIL done_after_reset: got status=%h irq=%b required 10 0", d, irq);
        end
        for (int i = 1; i <= 10; i++) begin
            bus_read(16'hDF00 + 16'(i), d, oe_m, oe_a);
            n_tests++;
            if (d !== exp_read(i)) begin
                n_fail++;
                $display("FAIL post_reset_read[%0d]: got %h required %h", i, d, exp_read(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_writes();
        test_random_regs();
        test_direct_start();
        test_ff00();
        test_irq();
        test_random_xfers();
        test_autoload_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
